// File: rtl/light_state_gen.sv
// Phase-code generator for the traffic-light controller: steps `state` through codes 0..7.
// Each code is held for a dwell counted in prescaled ticks. Optional macro: LSG_SENSOR_EN.

module light_state_gen #(
   parameter int TICK_DIV = 4,
   parameter int T_LONG   = 8,
   parameter int T_MID    = 3,
   parameter int T_SHORT  = 2,
   parameter int T_MIN    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req,
   output logic [2:0] state,
   output logic       phase_start,
   output logic       tick
);

   localparam int DMAX_LM = (T_LONG > T_MID) ? T_LONG : T_MID;
   localparam int DMAX    = (DMAX_LM > T_SHORT) ? DMAX_LM : T_SHORT;
   localparam int PW      = $clog2(TICK_DIV) + 1;
   localparam int DW      = $clog2(DMAX) + 1;

   localparam logic [PW-1:0] PSC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] TMIN_LAST = DW'(T_MIN - 1);

   typedef enum logic [2:0] {
      PH0 = 3'd0, PH1 = 3'd1, PH2 = 3'd2, PH3 = 3'd3,
      PH4 = 3'd4, PH5 = 3'd5, PH6 = 3'd6, PH7 = 3'd7
   } phase_e;

   phase_e          state_q, state_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [PW-1:0]   psc_q, psc_d;
   logic            tick_q, tick_d;
   logic            phase_start_q, phase_start_d;
   logic            tick_int;
   logic            early_end;

   // Last dwell-counter value of a code before it hands over to the next one.
   function automatic logic [DW-1:0] dwell_last(input phase_e s);
      case (s)
         PH0, PH4: dwell_last = DW'(T_LONG - 1);
         PH2, PH6: dwell_last = DW'(T_MID - 1);
         default:  dwell_last = DW'(T_SHORT - 1);
      endcase
   endfunction

   assign tick_int = en && (psc_q == PSC_LAST);

`ifdef LSG_SENSOR_EN
   assign early_end = (state_q == PH0 || state_q == PH4) && req && (dcnt_q >= TMIN_LAST);
`else
   assign early_end = 1'b0;
   logic unused_req;
   assign unused_req = req;
`endif

   // State register
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q       <= PH0;
         dcnt_q        <= '0;
         psc_q         <= '0;
         tick_q        <= 1'b0;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         psc_q         <= psc_d;
         tick_q        <= tick_d;
         phase_start_q <= phase_start_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latches).
      state_d       = state_q;
      dcnt_d        = dcnt_q;
      psc_d         = psc_q;
      tick_d        = tick_int;
      phase_start_d = 1'b0;

      if (en) begin
         psc_d = tick_int ? '0 : psc_q + PW'(1);
      end

      if (tick_int) begin
         if (dcnt_q == dwell_last(state_q) || early_end) begin
            state_d       = phase_e'(state_q + 3'd1);
            dcnt_d        = '0;
            phase_start_d = 1'b1;
         end else begin
            dcnt_d = dcnt_q + DW'(1);
         end
      end
   end

   // Output logic
   always_comb begin
      state       = state_q;
      phase_start = phase_start_q;
      tick        = tick_q;
   end

endmodule
